// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and constants for the multi-channel LED driver.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    localparam int DUTY_W = 8;

    // Channel-select width: $clog2 of the channel count, never below one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_ctrl_channel.sv
// led_channel: one LED channel holding mode, period, duty, phase and the
// registered LED bit. Optional macro LED_BREATHE_EN adds a triangular duty
// ramp in PWM mode.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int PER_W      = 10,
    parameter int RST_MODE   = 2,
    parameter int RST_PERIOD = 500
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              tick_i,
    input  logic [7:0]        pwm_cnt_i,
    input  logic              we_i,
    input  logic [1:0]        mode_i,
    input  logic [PER_W-1:0]  period_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              led_o
);

    mode_t              mode_q,   mode_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic [DUTY_W-1:0]  duty_q,   duty_d;
    logic [PER_W-1:0]   phase_q,  phase_d;
    logic               blink_q,  blink_d;
    logic               led_q,    led_d;
    logic [PER_W-1:0]   last_phase;
    logic [DUTY_W-1:0]  eff_duty;

    // A period of zero behaves as one: the last phase is then zero too.
    assign last_phase = (period_q == '0) ? '0 : period_q - 1'b1;

`ifdef LED_BREATHE_EN
    logic [DUTY_W-1:0]  ramp_q, ramp_d;
    logic               up_q,   up_d;

    // Triangular ramp 0..duty..0, one step per tick while in PWM mode.
    always_comb begin
        ramp_d = ramp_q;
        up_d   = up_q;
        if (we_i) begin
            ramp_d = '0;
            up_d   = 1'b1;
        end else if (tick_i && mode_q == MODE_PWM) begin
            if (duty_q == '0) begin
                ramp_d = '0;
                up_d   = 1'b1;
            end else if (up_q) begin
                if (ramp_q >= duty_q) begin
                    up_d   = 1'b0;
                    ramp_d = ramp_q - 1'b1;
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end else if (ramp_q == '0) begin
                up_d   = 1'b1;
                ramp_d = ramp_q + 1'b1;
            end else begin
                ramp_d = ramp_q - 1'b1;
            end
        end
    end

    // Ramp state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ramp_q <= '0;
            up_q   <= 1'b1;
        end else begin
            ramp_q <= ramp_d;
            up_q   <= up_d;
        end
    end

    assign eff_duty = ramp_q;
`else
    assign eff_duty = duty_q;
`endif

    // Config load, blink phase advance and LED value for the next cycle.
    // The LED bit follows the blink toggle state one clk later, so a write
    // (which clears that state) always restarts BLINK from a dark LED.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        phase_d  = phase_q;
        blink_d  = blink_q;
        led_d    = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = blink_q;
            MODE_PWM:   led_d = (pwm_cnt_i < eff_duty);
            default:    led_d = 1'b0;
        endcase
        if (we_i) begin
            mode_d   = mode_t'(mode_i);
            period_d = period_i;
            duty_d   = duty_i;
            phase_d  = '0;
            blink_d  = 1'b0;
        end else if (tick_i && mode_q == MODE_BLINK) begin
            if (phase_q == last_phase) begin
                phase_d = '0;
                blink_d = ~blink_q;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q   <= mode_t'(RST_MODE);
            period_q <= PER_W'(RST_PERIOD);
            duty_q   <= '0;
            phase_q  <= '0;
            blink_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            phase_q  <= phase_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: NCH-channel LED driver with shared tick prescaler and PWM counter.
// Optional macro LED_BREATHE_EN enables breathing PWM in every channel.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int PRESC      = 50000,
    parameter int PER_W      = 10,
    parameter int RST_MODE   = 2,
    parameter int RST_PERIOD = 500
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cfg_we,
    input  logic [ch_w(NCH)-1:0]  cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PER_W-1:0]      cfg_period,
    input  logic [DUTY_W-1:0]     cfg_duty,
    output logic                  tick_o,
    output logic [NCH-1:0]        led
);

    localparam int PR_W = $clog2(PRESC);

    logic [PR_W-1:0] presc_q, presc_d;
    logic            tick_q,  tick_d;
    logic [7:0]      pwm_q,   pwm_d;
    logic            ch_ok;

    // Prescaler wrap and free-running PWM count.
    always_comb begin
        tick_d  = (presc_q == PR_W'(PRESC - 1));
        presc_d = tick_d ? '0 : presc_q + 1'b1;
        pwm_d   = pwm_q + 8'd1;
    end

    // Shared timebase registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
        end
    end

    assign tick_o = tick_q;
    assign ch_ok  = cfg_we && (int'(cfg_ch) < NCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        led_channel #(
            .PER_W      (PER_W),
            .RST_MODE   (RST_MODE),
            .RST_PERIOD (RST_PERIOD)
        ) u_ch (
            .clk       (clk),
            .nrst      (nrst),
            .tick_i    (tick_q),
            .pwm_cnt_i (pwm_q),
            .we_i      (ch_ok && (int'(cfg_ch) == i)),
            .mode_i    (cfg_mode),
            .period_i  (cfg_period),
            .duty_i    (cfg_duty),
            .led_o     (led[i])
        );
    end

endmodule
